hc4_rom_loader: RTL

Upstream program-load stage for the HC4 core. It accepts a framed byte stream (from a UART receiver or test host) on a valid/ready interface and writes it into the core's 4096x8 program ROM through a synchronous write port. It also owns the core's reset: the core is held in reset while a frame is being received, and is released only after a frame passes its checksum. This lets the ROM be reloaded without touching the core's fetch logic.

---
 rtl/hc4_rom_loader_pkg.sv | 26 ++
 rtl/hc4_loader_timeout.sv | 34 +++
 rtl/hc4_rom_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hc4_rom_loader_pkg.sv
// Shared definitions for the HC4 program-ROM loader.
// Frame order: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA x N, CSUM.
// The state encoding below follows that field order one state per field.
package hc4_rom_loader_pkg;

  // One state per frame field; each advances on an accepted byte
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // hunting for SYNC
    S_AHI  = 3'd1,  // address high nibble
    S_ALO  = 3'd2,  // address low byte
    S_LHI  = 3'd3,  // (length-1) high nibble
    S_LLO  = 3'd4,  // (length-1) low byte
    S_DATA = 3'd5,  // payload bytes written to ROM
    S_CSUM = 3'd6   // trailing checksum byte
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE      = 8'hA5;
  localparam int         DEF_TIMEOUT_CYCLES = 65535;
  localparam int         HC4_ADDR_W         = 12;

  // Header high bytes only carry a 4-bit field; the upper nibble must be zero
  function automatic logic hdr_nibble_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/hc4_loader_timeout.sv
// Purpose: inter-byte idle watchdog for the loader (reloadable down-counter).
// Latency: expire is combinational, asserted during the TIMEOUT_CYCLES-th idle clock.
// Backpressure: none; it only observes activity and never stalls the stream.
module hc4_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,   // reload: an accepted byte, or no frame in progress
  input  logic en,      // count while a frame is in progress
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Reload on activity, otherwise count down the remaining idle budget
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(TIMEOUT_CYCLES);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Last idle clock of the budget: the loader aborts on this edge
  always_comb begin
    expire = en && !clear && (cnt == CW'(1));
  end

endmodule

// File: rtl/hc4_rom_loader.sv
// Purpose: parse framed byte stream, write payload to HC4 program ROM, own core reset.
// Latency: each data byte appears on the ROM write port 1 clock after it is accepted.
// Backpressure: none; rx_ready is high whenever out of reset, one byte per clock.
module hc4_rom_loader
  import hc4_rom_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int         ADDR_W         = HC4_ADDR_W
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_wdata,
  output logic              cpu_nReset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W-1:0] remain, remain_d;
  logic [7:0]        acc, acc_d, acc_sum;
  logic              rom_we_d, done_d, error_d, cpu_nreset_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        rom_wdata_d;
  logic              tmo_expire;

  assign rx_ready = nReset;
  assign busy     = (state != S_IDLE);
  assign acc_sum  = acc + rx_data;

  hc4_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .nReset (nReset),
    .clear  (!busy || rx_valid),
    .en     (busy),
    .expire (tmo_expire)
  );

  // State and output registers; reset puts the core back into reset
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= S_IDLE;
      addr       <= '0;
      remain     <= '0;
      acc        <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_nReset <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      remain     <= remain_d;
      acc        <= acc_d;
      rom_we     <= rom_we_d;
      rom_addr   <= rom_addr_d;
      rom_wdata  <= rom_wdata_d;
      cpu_nReset <= cpu_nreset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Frame parser: next state, header capture, ROM write and verdict
  always_comb begin
    state_d      = state;
    addr_d       = addr;
    remain_d     = remain;
    acc_d        = acc;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr;
    rom_wdata_d  = rom_wdata;
    cpu_nreset_d = cpu_nReset;
    done_d       = 1'b0;
    error_d      = error;

    if (rx_valid) begin
      if (state != S_IDLE) begin
        acc_d = acc_sum;
      end
      case (state)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            error_d      = 1'b0;
            cpu_nreset_d = 1'b0;
            acc_d        = '0;
            state_d      = S_AHI;
          end
        end
        S_AHI: begin
          if (!hdr_nibble_ok(rx_data)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = {rx_data[3:0], addr[7:0]};
            state_d = S_ALO;
          end
        end
        S_ALO: begin
          addr_d  = {addr[ADDR_W-1:8], rx_data};
          state_d = S_LHI;
        end
        S_LHI: begin
          if (!hdr_nibble_ok(rx_data)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            remain_d = {rx_data[3:0], remain[7:0]};
            state_d  = S_LLO;
          end
        end
        S_LLO: begin
          remain_d = {remain[ADDR_W-1:8], rx_data};
          state_d  = S_DATA;
        end
        S_DATA: begin
          rom_we_d    = 1'b1;
          rom_addr_d  = addr;
          rom_wdata_d = rx_data;
          addr_d      = addr + ADDR_W'(1);
          if (remain == '0) begin
            state_d = S_CSUM;
          end else begin
            remain_d = remain - ADDR_W'(1);
          end
        end
        S_CSUM: begin
          if (acc_sum == 8'h00) begin
            done_d       = 1'b1;
            cpu_nreset_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (tmo_expire) begin
      error_d = 1'b1;
      state_d = S_IDLE;
    end
  end

endmodule
